// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared configuration helpers for the pipelined carry-lookahead adder
//
// Purpose: derives the pipeline depth from the operand/grouping parameters and
// validates that the operand width splits evenly into lookahead stages.
// Ports: none (package).

package cla_pkg;

  // Pipeline depth: one stage per GROUP*GROUPS_PER_STAGE operand bits.
  function automatic int calc_stages(input int width, input int group, input int gps);
    return width / (group * gps);
  endfunction

  // Legal configuration: at least one bit per group, at least one group per
  // stage, and the operand width is a whole number of stages.
  function automatic bit cfg_ok(input int width, input int group, input int gps);
    if (group < 1 || gps < 1) begin
      return 1'b0;
    end
    return (width >= group * gps) && ((width % (group * gps)) == 0);
  endfunction

endpackage

// File: rtl/cla_group_gen.sv
// rtl/cla_group_gen.sv - flattened two-level carry-lookahead generator for one group
//
// Purpose: produces every internal carry of a GROUP-bit lookahead group directly
// from the group's propagate/generate terms and its carry in, without rippling.
// Ports:
//   P   in  [GROUP-1:0]  per-bit propagate (a ^ b)
//   G   in  [GROUP-1:0]  per-bit generate  (a & b)
//   Ci  in  1            carry into bit 0 of the group
//   C   out [GROUP:1]    C[i] = carry into bit i; C[GROUP] is the group carry out

module cla_group_gen #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] P,
  input  logic [GROUP-1:0] G,
  input  logic             Ci,
  output logic [GROUP:1]   C
);

  // Each carry is a sum of products:
  //   C[i] = G[i-1] | P[i-1]G[i-2] | ... | P[i-1..1]G[0] | P[i-1..0]Ci
  // The loops only build the product terms; no term depends on another carry.
  always_comb begin : p_lookahead
    logic acc;
    logic term;
    C    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int i = 1; i <= GROUP; i++) begin
      acc = Ci;
      for (int m = 0; m < i; m++) begin
        acc = acc & P[m];
      end
      for (int j = 0; j < i; j++) begin
        term = G[j];
        for (int m = j + 1; m < i; m++) begin
          term = term & P[m];
        end
        acc = acc | term;
      end
      C[i] = acc;
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
//
// Purpose: adds (SUB=0: A+B+Cin) or subtracts (SUB=1: A+~B+1) WIDTH-bit operands.
// An input capture rank registers the operands with B and the carry already
// resolved for the selected mode; STAGES lookahead ranks follow, each resolving
// GROUP*GROUPS_PER_STAGE bits and registering its carry out. The whole pipeline
// stalls as one when the output is held.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle
//   A, B       in   WIDTH  operands
//   Cin        in   1      carry in (ignored when SUB=1)
//   SUB        in   1      subtract select
//   out_valid  out  1      result beat present
//   out_ready  in   1      downstream accepts the result
//   S          out  WIDTH  sum / difference
//   Cout       out  1      carry out of the MSB (1 = no borrow when subtracting)
//   Ovf        out  1      two's-complement overflow

module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int GROUP            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int WS     = GROUP * GROUPS_PER_STAGE;
  localparam int STAGES = calc_stages(WIDTH, GROUP, GROUPS_PER_STAGE);

  if (!cfg_ok(WIDTH, GROUP, GROUPS_PER_STAGE)) begin : g_cfg_check
    $error("cla_pipe_adder: WIDTH must be a positive multiple of GROUP*GROUPS_PER_STAGE");
  end

  logic advance;

  // Input capture rank: mode already folded into B and the carry.
  logic             in_v_q, in_v_d;
  logic [WIDTH-1:0] in_a_q, in_a_d;
  logic [WIDTH-1:0] in_b_q, in_b_d;
  logic             in_c_q, in_c_d;

  // Lookahead ranks. a/b keep the full word; bits below the resolved boundary
  // are simply no longer looked at downstream.
  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic                         ovf_q, ovf_d;

  // Per-stage inputs (from the previous rank) and results.
  logic [STAGES-1:0]            st_v;
  logic [STAGES-1:0]            st_c;
  logic [STAGES-1:0][WIDTH-1:0] st_a;
  logic [STAGES-1:0][WIDTH-1:0] st_b;
  logic [STAGES-1:0][WIDTH-1:0] st_sum;
  logic [STAGES-1:0][WS-1:0]    slice_sum;
  logic [STAGES-1:0]            st_cout;
  logic                         msb_cin;

  // The last rank's operand copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_v[k]   = in_v_q;
      assign st_c[k]   = in_c_q;
      assign st_a[k]   = in_a_q;
      assign st_b[k]   = in_b_q;
      assign st_sum[k] = '0;
    end else begin : g_next
      assign st_v[k]   = v_q[k-1];
      assign st_c[k]   = c_q[k-1];
      assign st_a[k]   = a_q[k-1];
      assign st_b[k]   = b_q[k-1];
      assign st_sum[k] = sum_q[k-1];
    end

    for (genvar j = 0; j < GROUPS_PER_STAGE; j++) begin : g_grp
      localparam int LSB = k * WS + j * GROUP;

      logic [GROUP-1:0] p;
      logic [GROUP-1:0] g;
      logic [GROUP:1]   c;
      logic [GROUP:0]   cv;
      logic             ci;
      logic             co;

      // Group carries chain combinationally inside one stage.
      if (j == 0) begin : g_c0
        assign ci = st_c[k];
      end else begin : g_cn
        assign ci = g_grp[j-1].co;
      end

      assign p  = st_a[k][LSB +: GROUP] ^ st_b[k][LSB +: GROUP];
      assign g  = st_a[k][LSB +: GROUP] & st_b[k][LSB +: GROUP];

      cla_group_gen #(
        .GROUP (GROUP)
      ) u_gen (
        .P  (p),
        .G  (g),
        .Ci (ci),
        .C  (c)
      );

      assign cv = {c, ci};
      assign co = c[GROUP];
      assign slice_sum[k][j*GROUP +: GROUP] = p ^ cv[GROUP-1:0];

      if (j == GROUPS_PER_STAGE - 1) begin : g_stage_co
        assign st_cout[k] = co;
      end
      // Carry into the word MSB lives in the top group of the last stage.
      if (k == STAGES - 1 && j == GROUPS_PER_STAGE - 1) begin : g_msb
        assign msb_cin = cv[GROUP-1];
      end
    end
  end

  assign advance = ~v_q[STAGES-1] | out_ready;

  always_comb begin
    in_v_d = in_valid;
    in_a_d = A;
    in_b_d = SUB ? ~B : B;
    in_c_d = SUB | Cin;
    v_d    = st_v;
    a_d    = st_a;
    b_d    = st_b;
    c_d    = st_cout;
    sum_d  = st_sum;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*WS +: WS] = slice_sum[k];
    end
    ovf_d  = msb_cin ^ st_cout[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_q <= 1'b0;
      in_a_q <= '0;
      in_b_q <= '0;
      in_c_q <= 1'b0;
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (advance) begin
      in_v_q <= in_v_d;
      in_a_q <= in_a_d;
      in_b_q <= in_b_d;
      in_c_q <= in_c_d;
      v_q    <= v_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign S         = sum_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder (16-bit, 2 stages)

module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         SUB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  cla_pipe_adder #(
    .WIDTH            (W),
    .GROUP            (4),
    .GROUPS_PER_STAGE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[10];
  res_t exp_q[$];
  int   checks;
  int   errors;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c0;
    res_t         r;
    bb     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input res_t e);
    bit acc;
    int waited;
    A        = a;
    B        = b;
    Cin      = cin;
    SUB      = sub;
    in_valid = 1'b1;
    exp_q.push_back(e);
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic monitor();
    res_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", {S, Cout, Ovf});
        end else begin
          e = exp_q.pop_front();
          if ({S, Cout, Ovf} !== e) begin
            errors++;
            $display("FAIL result actual S=%h C=%b V=%b required S=%h C=%b V=%b",
                     S, Cout, Ovf, e.s, e.cout, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          n;
    logic [W-1:0] hs;
    logic         hc;
    logic         ho;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    SUB       = 1'b0;
    out_ready = 1'b1;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_Ovf", 32'(Ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency from the accepting edge to out_valid is STAGES (=2) edges.
    send(16'h0101, 16'h0202, 1'b0, 1'b0, model(16'h0101, 16'h0202, 1'b0, 1'b0));
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", 32'(n), 32'd2);
    wait_drain();

    // Directed vectors, streamed back to back.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
           res_t'({tbl[i].s, tbl[i].cout, tbl[i].ovf}));
    end
    wait_drain();

    // Backpressure: 6 random beats, output held for 3 cycles at the first result.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [W-1:0] ra;
          logic [W-1:0] rb;
          logic         rc;
          logic         rs;
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom);
          rs = 1'($urandom);
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        int m;
        m = 0;
        while (!out_valid && m < 50) begin
          @(posedge clk);
          #1;
          m++;
        end
        chk("bp_first_output", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        hs = S;
        hc = Cout;
        ho = Ovf;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          chk("bp_stable", 32'({S, Cout, Ovf}), 32'({hs, hc, ho}));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-flight with the output blocked: both beats must vanish.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h4444, 1'b1, 1'b0, model(16'h3333, 16'h4444, 1'b1, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_S", 32'(S), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_stale", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
